// File: rtl/mips_md_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes, FSM states and
// small decode helpers used by the sequencer and its bench.
package mips_md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Codes 5-7 are reserved and behave like MD_NONE.
  function automatic logic md_op_valid(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_op_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_sequencer_if.sv
// ID/EX-side request and HI/LO result bundle of the multiply/divide sequencer.
interface mult_div_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [2:0]            ID_EX_MultDivOp;
  logic                  ID_EX_ReadHiLo;
  logic                  ID_EX_WriteHi;
  logic                  ID_EX_WriteLo;
  logic                  ID_EX_Flush;
  logic [DATA_WIDTH-1:0] ID_EX_OpA;
  logic [DATA_WIDTH-1:0] ID_EX_OpB;
  logic                  MD_Stall;
  logic                  MD_Busy;
  logic                  MD_DivByZero;
  logic [DATA_WIDTH-1:0] Hi;
  logic [DATA_WIDTH-1:0] Lo;

  modport master (
    output ID_EX_MultDivOp, ID_EX_ReadHiLo, ID_EX_WriteHi, ID_EX_WriteLo, ID_EX_Flush,
    output ID_EX_OpA, ID_EX_OpB,
    input  MD_Stall, MD_Busy, MD_DivByZero, Hi, Lo
  );

  modport slave (
    input  ID_EX_MultDivOp, ID_EX_ReadHiLo, ID_EX_WriteHi, ID_EX_WriteLo, ID_EX_Flush,
    input  ID_EX_OpA, ID_EX_OpB,
    output MD_Stall, MD_Busy, MD_DivByZero, Hi, Lo
  );

endinterface

// File: rtl/md_iter_datapath.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on unsigned magnitudes.
// {hi,lo} is one 64-bit shift register; lo starts as multiplier or dividend.
module md_iter_datapath #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  op_is_div_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic                    div_q, div_d;

  logic [DATA_WIDTH-1:0]   acc_hi, acc_lo, diff;
  logic [DATA_WIDTH:0]     addend, trial;
  logic                    fits;

  always_comb begin
    acc_d  = acc_q;
    opb_d  = opb_q;
    div_d  = div_q;
    acc_hi = acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
    acc_lo = acc_q[DATA_WIDTH-1:0];
    addend = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opb_q}) : {1'b0, acc_hi};
    trial  = {acc_hi, acc_lo[DATA_WIDTH-1]};
    // A zero divisor always fits, giving an all-ones quotient and the dividend as remainder.
    fits   = trial >= {1'b0, opb_q};
    diff   = trial[DATA_WIDTH-1:0] - opb_q;
    if (load_i) begin
      div_d = op_is_div_i;
      opb_d = op_is_div_i ? op_b_i : op_a_i;
      acc_d = {{DATA_WIDTH{1'b0}}, (op_is_div_i ? op_a_i : op_b_i)};
    end else if (step_i) begin
      if (div_q) begin
        acc_d = fits ? {diff, acc_lo[DATA_WIDTH-2:0], 1'b1}
                     : {trial[DATA_WIDTH-1:0], acc_lo[DATA_WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {addend, acc_lo[DATA_WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      div_q <= div_d;
    end
  end

  assign hi_o = acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign lo_o = acc_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/mult_div_sequencer.sv
// Sequences the shared iterative multiply/divide unit, owns HI/LO and stalls dependent
// instructions while the unit runs in the background.
module mult_div_sequencer
  import mips_md_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                 Clk,
  input  logic                 Rst,
  mult_div_sequencer_if.slave  bus
);

  md_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  is_div_q, is_div_d;
  logic                  quot_neg_q, quot_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic                  dbz_q, dbz_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic                    op_valid, op_is_div, start, load, step;
  logic                    sign_a, sign_b;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b, raw_hi, raw_lo;
  logic [2*DATA_WIDTH-1:0] prod;

  // Issue decode and operand magnitudes
  always_comb begin
    op_valid  = md_op_valid(bus.ID_EX_MultDivOp);
    op_is_div = md_op_is_div(bus.ID_EX_MultDivOp);
    start     = (state_q == MD_IDLE) && !bus.ID_EX_Flush && op_valid;
    sign_a    = md_op_signed(bus.ID_EX_MultDivOp) && bus.ID_EX_OpA[DATA_WIDTH-1];
    sign_b    = md_op_signed(bus.ID_EX_MultDivOp) && bus.ID_EX_OpB[DATA_WIDTH-1];
    mag_a     = sign_a ? -bus.ID_EX_OpA : bus.ID_EX_OpA;
    mag_b     = sign_b ? -bus.ID_EX_OpB : bus.ID_EX_OpB;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (start) state_d = MD_RUN;
      MD_RUN:  if (cnt_q == '0) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    load             = start;
    step             = (state_q == MD_RUN);
    bus.MD_Busy      = (state_q != MD_IDLE);
    bus.MD_DivByZero = (state_q == MD_FIX) && dbz_q;
    bus.MD_Stall     = (state_q != MD_IDLE) && !bus.ID_EX_Flush &&
                       (op_valid || bus.ID_EX_ReadHiLo || bus.ID_EX_WriteHi || bus.ID_EX_WriteLo);
    bus.Hi           = hi_q;
    bus.Lo           = lo_q;
  end

  md_iter_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .load_i      (load),
    .step_i      (step),
    .op_is_div_i (op_is_div),
    .op_a_i      (mag_a),
    .op_b_i      (mag_b),
    .hi_o        (raw_hi),
    .lo_o        (raw_lo)
  );

  always_comb begin
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_d      = dbz_q;
    opa_d      = opa_q;
    if (start) begin
      cnt_d      = CNT_WIDTH'(DATA_WIDTH - 1);
      is_div_d   = op_is_div;
      quot_neg_d = sign_a ^ sign_b;
      rem_neg_d  = sign_a;
      dbz_d      = op_is_div && (bus.ID_EX_OpB == '0);
      opa_d      = bus.ID_EX_OpA;
    end else if (state_q == MD_RUN) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    prod = quot_neg_q ? -{raw_hi, raw_lo} : {raw_hi, raw_lo};
    if (state_q == MD_FIX) begin
      if (is_div_q && dbz_q) begin
        hi_d = opa_q;
        lo_d = '1;
      end else if (is_div_q) begin
        hi_d = rem_neg_q ? -raw_hi : raw_hi;
        lo_d = quot_neg_q ? -raw_lo : raw_lo;
      end else begin
        {hi_d, lo_d} = prod;
      end
    end else if ((state_q == MD_IDLE) && !bus.ID_EX_Flush) begin
      if (bus.ID_EX_WriteHi) hi_d = bus.ID_EX_OpA;
      if (bus.ID_EX_WriteLo) lo_d = bus.ID_EX_OpA;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_q      <= 1'b0;
      opa_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_q      <= dbz_d;
      opa_q      <= opa_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: directed ops push expected HI/LO, a monitor
// compares them whenever the unit drops MD_Busy.
module tb_mult_div_sequencer;
  import mips_md_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_sequencer_if #(.DATA_WIDTH(32)) bus ();

  mult_div_sequencer #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (5)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   dbz_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_op(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    sb_q.push_back(e);
  endtask

  // Completion monitor: a busy->idle drop not caused by reset retires one scoreboard entry.
  initial begin : monitor
    logic busy_prev;
    logic rst_prev;
    exp_t e;
    busy_prev = 1'b0;
    rst_prev  = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.MD_DivByZero) dbz_cnt++;
      if (busy_prev && !bus.MD_Busy && !rst && !rst_prev) begin
        if (sb_q.size() == 0) begin
          check("scoreboard entry present", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          check({e.name, " hi"}, 64'(bus.Hi), 64'(e.hi));
          check({e.name, " lo"}, 64'(bus.Lo), 64'(e.lo));
        end
      end
      busy_prev = bus.MD_Busy;
      rst_prev  = rst;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_idle();
    bus.ID_EX_MultDivOp = MD_NONE;
    bus.ID_EX_ReadHiLo  = 1'b0;
    bus.ID_EX_WriteHi   = 1'b0;
    bus.ID_EX_WriteLo   = 1'b0;
    bus.ID_EX_Flush     = 1'b0;
    bus.ID_EX_OpA       = '0;
    bus.ID_EX_OpB       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ID_EX_MultDivOp = op;
    bus.ID_EX_OpA       = a;
    bus.ID_EX_OpB       = b;
    tick();
    bus.ID_EX_MultDivOp = MD_NONE;
  endtask

  // Counts busy and stalled cycles until the first idle negedge, bounded.
  task automatic run_until_idle(output int busy_n, output int stall_n);
    busy_n  = 0;
    stall_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.MD_Busy) return;
      busy_n++;
      if (bus.MD_Stall) stall_n++;
    end
    total++;
    bad++;
    $display("FAIL busy timeout: busy for %0d cycles, required idle within 100", busy_n);
  endtask

  initial begin : stimulus
    int b;
    int s;
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    check("reset hi", 64'(bus.Hi), 64'd0);
    check("reset lo", 64'(bus.Lo), 64'd0);
    check("reset busy", 64'(bus.MD_Busy), 64'd0);
    check("reset stall", 64'(bus.MD_Stall), 64'd0);
    check("reset dbz", 64'(bus.MD_DivByZero), 64'd0);
    rst = 1'b0;
    tick();

    // MULT -3 * 7
    expect_op("mult -3*7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    run_until_idle(b, s);
    check("mult busy cycles", 64'(b), 64'd33);
    check("mult stall cycles", 64'(s), 64'd0);
    tick();

    // DIVU 100/7 with MFLO arriving two cycles after the start
    expect_op("divu 100/7", 32'd2, 32'd14);
    issue(MD_DIVU, 32'd100, 32'd7);
    tick();
    bus.ID_EX_ReadHiLo = 1'b1;
    run_until_idle(b, s);
    check("mflo busy cycles", 64'(b), 64'd32);
    check("mflo stall cycles", 64'(s), 64'd32);
    check("mflo stall released", 64'(bus.MD_Stall), 64'd0);
    check("mflo reads quotient", 64'(bus.Lo), 64'd14);
    tick();
    bus.ID_EX_ReadHiLo = 1'b0;

    // Signed divide, divide by zero, signed overflow
    expect_op("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_until_idle(b, s);
    tick();

    dbz_cnt = 0;
    expect_op("divu 0x1234/0", 32'h0000_1234, 32'hFFFF_FFFF);
    issue(MD_DIVU, 32'h0000_1234, 32'd0);
    run_until_idle(b, s);
    check("divu/0 dbz pulses", 64'(dbz_cnt), 64'd1);
    tick();

    dbz_cnt = 0;
    expect_op("div -5/0", 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    issue(MD_DIV, 32'hFFFF_FFFB, 32'd0);
    run_until_idle(b, s);
    check("div/0 dbz pulses", 64'(dbz_cnt), 64'd1);
    tick();

    dbz_cnt = 0;
    expect_op("div overflow", 32'd0, 32'h8000_0000);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_until_idle(b, s);
    check("overflow dbz pulses", 64'(dbz_cnt), 64'd0);
    tick();

    // Flushed MULTU never starts
    bus.ID_EX_Flush = 1'b1;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive_idle();
    check("flushed op busy", 64'(bus.MD_Busy), 64'd0);
    check("flushed op hi", 64'(bus.Hi), 64'd0);
    check("flushed op lo", 64'(bus.Lo), 64'h8000_0000);

    expect_op("multu max*max", 32'hFFFF_FFFE, 32'h0000_0001);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_until_idle(b, s);
    tick();

    // Flushed MTLO in idle must not write
    bus.ID_EX_WriteLo = 1'b1;
    bus.ID_EX_Flush   = 1'b1;
    bus.ID_EX_OpA     = 32'hDEAD_BEEF;
    tick();
    drive_idle();
    check("flushed mtlo lo", 64'(bus.Lo), 64'h0000_0001);

    // Flush while busy: no stall, no abort; then MTHI stalls and overwrites the result
    expect_op("mult 5*6", 32'd0, 32'd30);
    issue(MD_MULT, 32'd5, 32'd6);
    bus.ID_EX_ReadHiLo = 1'b1;
    bus.ID_EX_Flush    = 1'b1;
    @(negedge clk);
    check("flushed mfhi stall", 64'(bus.MD_Stall), 64'd0);
    bus.ID_EX_ReadHiLo = 1'b0;
    bus.ID_EX_Flush    = 1'b0;
    bus.ID_EX_WriteHi  = 1'b1;
    bus.ID_EX_OpA      = 32'h0000_00AA;
    run_until_idle(b, s);
    check("mthi busy cycles", 64'(b), 64'd32);
    check("mthi stall cycles", 64'(s), 64'd32);
    tick();
    drive_idle();
    check("mthi after op hi", 64'(bus.Hi), 64'h0000_00AA);
    check("mthi after op lo", 64'(bus.Lo), 64'd30);

    // MTHI and MTLO together
    bus.ID_EX_WriteHi = 1'b1;
    bus.ID_EX_WriteLo = 1'b1;
    bus.ID_EX_OpA     = 32'h0000_0055;
    tick();
    drive_idle();
    check("mthi+mtlo hi", 64'(bus.Hi), 64'h0000_0055);
    check("mthi+mtlo lo", 64'(bus.Lo), 64'h0000_0055);

    // Back-to-back: second MULT stalls and starts right after the single idle cycle
    expect_op("multu 3*4", 32'd0, 32'd12);
    issue(MD_MULTU, 32'd3, 32'd4);
    expect_op("mult -2*3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    bus.ID_EX_MultDivOp = MD_MULT;
    bus.ID_EX_OpA       = 32'hFFFF_FFFE;
    bus.ID_EX_OpB       = 32'd3;
    run_until_idle(b, s);
    check("b2b first busy", 64'(b), 64'd33);
    check("b2b stall cycles", 64'(s), 64'd33);
    check("b2b idle no stall", 64'(bus.MD_Stall), 64'd0);
    tick();
    drive_idle();
    check("b2b second started", 64'(bus.MD_Busy), 64'd1);
    run_until_idle(b, s);
    check("b2b second busy", 64'(b), 64'd33);
    tick();

    // Reset in RUN cycle 10 aborts without HI/LO update, then a DIV runs normally
    issue(MD_MULT, 32'd9, 32'd9);
    repeat (9) tick();
    rst                = 1'b1;
    bus.ID_EX_ReadHiLo = 1'b1;
    tick();
    check("abort busy", 64'(bus.MD_Busy), 64'd0);
    check("abort stall", 64'(bus.MD_Stall), 64'd0);
    check("abort hi", 64'(bus.Hi), 64'd0);
    check("abort lo", 64'(bus.Lo), 64'd0);
    rst = 1'b0;
    drive_idle();
    tick();

    expect_op("div 100/-7", 32'd2, 32'hFFFF_FFF2);
    issue(MD_DIV, 32'd100, 32'hFFFF_FFF9);
    run_until_idle(b, s);
    check("post-reset busy", 64'(b), 64'd33);
    tick();
    tick();

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
